prod_acc: RTL

PROD_ACC -- requirements
Module: prod_acc

---
 rtl/prod_acc_pkg.sv | 16 +
 rtl/prod_acc.sv | 108 ++++++++++
 2 files changed

// File: rtl/prod_acc_pkg.sv
// Shared definitions for the product accumulator.
//   state_t    : accumulator FSM states (IDLE, ACC, HOLD)
//   ACC_W_DEF  : default accumulator / out_sum width
//   CNT_W_DEF  : default term-counter width
package prod_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/prod_acc.sv
// Product accumulator: sums a stream of unsigned 16-bit product terms into
// one dot-product result, then holds it until the consumer takes it.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : term handshake; in_prod is the term and
//                           in_last marks the final term of a dot product
//   out_valid/out_ready   : result handshake
//   out_sum               : accumulated sum (ACC_W bits, wraps)
//   out_count             : number of accepted terms (CNT_W bits, wraps)
//   out_ovf               : sticky wrap flag for sum or count
module prod_acc
    import prod_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic               ready_q, ready_nxt;
    logic               take;
    logic [ACC_W:0]     sum_ext;
    logic [CNT_W:0]     cnt_inc;

    assign take    = in_valid & ready_q;
    // One extra bit on each adder exposes the wrap carry for the ovf flag.
    assign sum_ext = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, in_prod};
    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_nxt   = {{(ACC_W - 16){1'b0}}, in_prod};
                    cnt_nxt   = CNT_W'(1);
                    ovf_nxt   = 1'b0;
                    state_nxt = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (take) begin
                    acc_nxt = sum_ext[ACC_W-1:0];
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                    ovf_nxt = ovf | sum_ext[ACC_W] | cnt_inc[CNT_W];
                    if (in_last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is registered from the next state, so it never depends
    // combinationally on out_ready and stays low through reset.
    assign ready_nxt = (state_nxt != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            ovf     <= ovf_nxt;
            ready_q <= ready_nxt;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule
